// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Staged reset release sequencer. While the upstream stretched reset request
// is high, every downstream domain is held in reset. Once the request falls,
// the domains are released one at a time in index order. Each release follows
// a programmable delay. The next stage is only considered after the current
// stage reports ready.
//
// Optional feature macro: RESET_SEQ_TIMEOUT_EN
//   defined   - a timeout counter watches each ready wait. On expiry the block
//               enters FAULT, re-asserts every reset and raises op_timeout_o.
//   undefined - the ready wait blocks indefinitely, op_timeout_o is tied low,
//               and no timeout counter exists.
//
// Ports:
//   clk               system clock, rising edge
//   ip_reset_n_i      synchronous active-low block reset
//   ip_reset_req_i    active-high reset request from the reset stretcher
//   ip_stage_ready_i  per-stage ready, already synchronous to clk
//   op_stage_reset_o  per-stage active-high reset, bit i drives domain i
//   op_done_o         all stages released and ready
//   op_timeout_o      high while in FAULT
//   op_state_o        HOLD=0, DELAY=1, WAIT=2, DONE=3, FAULT=4
//   op_stage_idx_o    index of the stage currently being sequenced

module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 64,
    parameter int TIMEOUT     = 65536
) (
    input  logic                  clk,
    input  logic                  ip_reset_n_i,
    input  logic                  ip_reset_req_i,
    input  logic [NUM_STAGES-1:0] ip_stage_ready_i,
    output logic [NUM_STAGES-1:0] op_stage_reset_o,
    output logic                  op_done_o,
    output logic                  op_timeout_o,
    output logic [2:0]            op_state_o,
    output logic [3:0]            op_stage_idx_o
);

    // The counter is wide enough for the larger of the two limits, so neither
    // count can ever wrap before it is compared.
    localparam int MAX_COUNT = (STAGE_DELAY > TIMEOUT) ? STAGE_DELAY : TIMEOUT;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0]      DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [3:0]            LAST_IDX   = 4'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES   = '1;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        DELAY = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t                state;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  done_flag;
    logic [3:0]            stage_idx;
    logic [CNT_W-1:0]      delay_cnt;
    logic                  ready_cur;
    logic [NUM_STAGES-1:0] stage_sel;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_flag;
`endif

    // Decode the current stage index into a one-hot select and pick out that
    // stage's ready bit. A loop compare avoids indexing a narrow vector with
    // the wider 4-bit index.
    always_comb begin
        ready_cur = 1'b0;
        stage_sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_idx == 4'(i)) begin
                ready_cur    = ip_stage_ready_i[i];
                stage_sel[i] = 1'b1;
            end
        end
    end

    // Sequencer FSM. The block reset overrides everything. A reset request
    // then overrides every other transition and returns to HOLD.
    always_ff @(posedge clk) begin
        if (!ip_reset_n_i) begin
            state       <= HOLD;
            stage_reset <= ALL_ONES;
            done_flag   <= 1'b0;
            stage_idx   <= 4'd0;
            delay_cnt   <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_cnt  <= '0;
            timeout_flag <= 1'b0;
`endif
        end else if (ip_reset_req_i) begin
            state       <= HOLD;
            stage_reset <= ALL_ONES;
            done_flag   <= 1'b0;
            stage_idx   <= 4'd0;
            delay_cnt   <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_cnt  <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    state     <= DELAY;
                    delay_cnt <= '0;
                end

                // The counter reaching DELAY_LAST is seen one edge later,
                // so the release lands exactly STAGE_DELAY edges after entry.
                DELAY: begin
                    if (delay_cnt == DELAY_LAST) begin
                        stage_reset <= stage_reset & ~stage_sel;
                        state       <= WAIT;
                        delay_cnt   <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
                        timeout_cnt <= '0;
`endif
                    end else begin
                        delay_cnt <= delay_cnt + CNT_W'(1);
                    end
                end

                // Ready is accepted even on the edge the timeout would expire.
                WAIT: begin
                    if (ready_cur) begin
                        if (stage_idx == LAST_IDX) begin
                            state     <= DONE;
                            done_flag <= 1'b1;
                        end else begin
                            state     <= DELAY;
                            stage_idx <= stage_idx + 4'd1;
                        end
                        delay_cnt <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state        <= FAULT;
                        stage_reset  <= ALL_ONES;
                        timeout_flag <= 1'b1;
                        done_flag    <= 1'b0;
                        timeout_cnt  <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
`endif
                    end
                end

                // DONE and FAULT only leave through a reset request.
                DONE: begin
                    done_flag <= 1'b1;
                end

                FAULT: begin
                    stage_reset <= ALL_ONES;
                end

                default: begin
                    state       <= HOLD;
                    stage_reset <= ALL_ONES;
                    done_flag   <= 1'b0;
                    stage_idx   <= 4'd0;
                    delay_cnt   <= '0;
                end
            endcase
        end
    end

    assign op_stage_reset_o = stage_reset;
    assign op_done_o        = done_flag;
    assign op_state_o       = state;
    assign op_stage_idx_o   = stage_idx;

`ifdef RESET_SEQ_TIMEOUT_EN
    assign op_timeout_o = timeout_flag;
`else
    assign op_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer with NUM_STAGES=4, STAGE_DELAY=8
// and TIMEOUT=100. Expected outputs are queued when stimulus is applied and
// then compared once the DUT has clocked. The timeout scenario or the
// compiled-out scenario is selected by RESET_SEQ_TIMEOUT_EN.

module tb_reset_sequencer;

    localparam int NS = 4;
    localparam int SD = 8;
    localparam int TO = 100;

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req;
    logic [NS-1:0] ready;
    logic [NS-1:0] stage_reset;
    logic          done;
    logic          timeout;
    logic [2:0]    state;
    logic [3:0]    stage_idx;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string      name;
        logic [3:0] resets;
        logic       done;
        logic       tmo;
        logic [2:0] state;
        logic [3:0] idx;
        logic       chkIdx;
    } exp_t;

    typedef struct {
        string      name;
        logic       rstN;
        logic       req;
        logic [3:0] ready;
        int         cycles;
        logic [3:0] resets;
        logic       done;
        logic       tmo;
        logic [2:0] state;
        logic [3:0] idx;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    reset_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_DELAY(SD),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .ip_reset_n_i    (reset_n),
        .ip_reset_req_i  (req),
        .ip_stage_ready_i(ready),
        .op_stage_reset_o(stage_reset),
        .op_done_o       (done),
        .op_timeout_o    (timeout),
        .op_state_o      (state),
        .op_stage_idx_o  (stage_idx)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rn, input logic rq, input logic [3:0] rd);
        reset_n = rn;
        req     = rq;
        ready   = rd;
    endtask

    task automatic pushExpected(input string nm, input logic [3:0] rs, input logic dn,
                                input logic tm, input logic [2:0] st, input logic [3:0] ix,
                                input logic ci);
        exp_t e;
        e.name   = nm;
        e.resets = rs;
        e.done   = dn;
        e.tmo    = tm;
        e.state  = st;
        e.idx    = ix;
        e.chkIdx = ci;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        logic ok;
        testsRun++;
        if (sb.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e  = sb.pop_front();
        ok = (stage_reset === e.resets) && (done === e.done) && (timeout === e.tmo) &&
             (state === e.state) && (!e.chkIdx || (stage_idx === e.idx));
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL %s: got resets=%b done=%b timeout=%b state=%0d idx=%0d, required resets=%b done=%b timeout=%b state=%0d idx=%0d",
                     e.name, stage_reset, done, timeout, state, stage_idx,
                     e.resets, e.done, e.tmo, e.state, e.idx);
        end
    endtask

    // Expected outputs k edges after T0 when every ready is high: each stage
    // spends SD edges in DELAY and one in WAIT. DONE follows at k=36.
    function automatic void expFast(input int k, output logic [3:0] rs, output logic dn,
                                    output logic [2:0] st, output logic [3:0] ix);
        logic [3:0] ones;
        int i;
        int r;
        int n;
        ones = 4'b1111;
        i = k / (SD + 1);
        r = k % (SD + 1);
        if (k >= NS * (SD + 1)) begin
            rs = 4'b0000;
            dn = 1'b1;
            st = S_DONE;
            ix = 4'(NS - 1);
        end else begin
            n  = i + ((r == SD) ? 1 : 0);
            rs = ones << n;
            dn = 1'b0;
            st = (r == SD) ? S_WAIT : S_DELAY;
            ix = 4'(i);
        end
    endfunction

    task automatic pulseRequest(input string nm);
        applyStimulus(1'b1, 1'b1, 4'hF);
        pushExpected(nm, 4'b1111, 1'b0, 1'b0, S_HOLD, 4'd0, 1'b1);
        tick();
        checkOutput();
    endtask

    initial begin
        logic [3:0] rs;
        logic       dn;
        logic [2:0] st;
        logic [3:0] ix;

        vecs[0] = '{"power_up",        1'b0, 1'b1, 4'h0, 3, 4'b1111, 1'b0, 1'b0, S_HOLD, 4'd0};
        vecs[1] = '{"hold_while_req",  1'b1, 1'b1, 4'hF, 2, 4'b1111, 1'b0, 1'b0, S_HOLD, 4'd0};
        vecs[2] = '{"first_release",   1'b1, 1'b0, 4'hF, 9, 4'b1110, 1'b0, 1'b0, S_WAIT, 4'd0};
        vecs[3] = '{"reset_n_override",1'b0, 1'b0, 4'hF, 1, 4'b1111, 1'b0, 1'b0, S_HOLD, 4'd0};
        vecs[4] = '{"back_to_hold",    1'b1, 1'b1, 4'hF, 1, 4'b1111, 1'b0, 1'b0, S_HOLD, 4'd0};

        applyStimulus(1'b0, 1'b1, 4'h0);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].rstN, vecs[v].req, vecs[v].ready);
            pushExpected(vecs[v].name, vecs[v].resets, vecs[v].done, vecs[v].tmo,
                         vecs[v].state, vecs[v].idx, 1'b1);
            repeat (vecs[v].cycles) tick();
            checkOutput();
        end

        // Ready already high: releases at T0+8/17/26/35, done at T0+36.
        applyStimulus(1'b1, 1'b0, 4'hF);
        for (int k = 0; k <= 44; k++) begin
            expFast(k, rs, dn, st, ix);
            pushExpected($sformatf("ready_high_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            tick();
            checkOutput();
        end
        pulseRequest("req_from_done");

        // Late ready: ready[1] is first sampled at edge 58, 41 edges after
        // reset[1] falls. Ready[0] drops after acceptance and ready[3] is
        // high early; both must be ignored.
        for (int k = 0; k <= 70; k++) begin
            applyStimulus(1'b1, 1'b0, {1'b1, 1'b0, (k >= 58) ? 1'b1 : 1'b0, (k <= 9) ? 1'b1 : 1'b0});
            if (k < 9) begin
                expFast(k, rs, dn, st, ix);
            end else if (k < 17) begin
                rs = 4'b1110; dn = 1'b0; st = S_DELAY; ix = 4'd1;
            end else if (k < 58) begin
                rs = 4'b1100; dn = 1'b0; st = S_WAIT;  ix = 4'd1;
            end else if (k < 66) begin
                rs = 4'b1100; dn = 1'b0; st = S_DELAY; ix = 4'd2;
            end else begin
                rs = 4'b1000; dn = 1'b0; st = S_WAIT;  ix = 4'd2;
            end
            pushExpected($sformatf("late_ready_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            tick();
            checkOutput();
        end
        pulseRequest("req_after_late_ready");

        // Mid-sequence request while stage 2 is in DELAY, then restart.
        applyStimulus(1'b1, 1'b0, 4'hF);
        for (int k = 0; k < 20; k++) begin
            expFast(k, rs, dn, st, ix);
            pushExpected($sformatf("mid_pre_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            tick();
            checkOutput();
        end
        pulseRequest("mid_sequence_req");
        applyStimulus(1'b1, 1'b0, 4'hF);
        for (int k = 0; k <= 12; k++) begin
            expFast(k, rs, dn, st, ix);
            pushExpected($sformatf("mid_restart_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            tick();
            checkOutput();
        end
        pulseRequest("req_after_restart");

`ifdef RESET_SEQ_TIMEOUT_EN
        // Stage 2 never ready: WAIT entered at edge 26, FAULT at 126.
        applyStimulus(1'b1, 1'b0, 4'b0011);
        for (int k = 0; k <= 130; k++) begin
            if (k < 26) begin
                expFast(k, rs, dn, st, ix);
                pushExpected($sformatf("timeout_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            end else if (k < 26 + TO) begin
                pushExpected($sformatf("timeout_wait_k%0d", k), 4'b1000, 1'b0, 1'b0, S_WAIT, 4'd2, 1'b1);
            end else begin
                pushExpected($sformatf("timeout_fault_k%0d", k), 4'b1111, 1'b0, 1'b1, S_FAULT, 4'd2, 1'b0);
            end
            tick();
            checkOutput();
        end
        pulseRequest("req_clears_fault");
        applyStimulus(1'b1, 1'b0, 4'hF);
        for (int k = 0; k <= 10; k++) begin
            expFast(k, rs, dn, st, ix);
            pushExpected($sformatf("fault_restart_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            tick();
            checkOutput();
        end
`else
        // Without the timeout feature, WAIT on stage 0 never gives up.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        for (int k = 0; k <= 10008; k++) begin
            if (k < SD) begin
                expFast(k, rs, dn, st, ix);
                pushExpected($sformatf("no_timeout_k%0d", k), rs, dn, 1'b0, st, ix, 1'b1);
            end else begin
                pushExpected($sformatf("no_timeout_wait_k%0d", k), 4'b1110, 1'b0, 1'b0, S_WAIT, 4'd0, 1'b1);
            end
            tick();
            checkOutput();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
